uart_word_sched: RTL

Two-channel scheduler that shares the 32-bit word UART transmitter between two synchronous FIFOs, for example the FFT real-part and imaginary-part result FIFOs. It arbitrates round-robin between non-empty channels and prefixes each burst with a header word. It then reads up to `BURST_LEN` words from the granted FIFO and hands each word to the transmitter with a start/done handshake. It sits between the FIFO stage and `uart_tx` in the FFT→FIFO→UART chain.

---
 rtl/uart_sched_pkg.sv | 48 ++++
 rtl/uart_word_sched_rr_arb2.sv | 47 ++++
 rtl/uart_word_sched.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_sched_pkg
//  Description : Shared types and constants for the two-channel UART word
//                scheduler: FSM state encoding, header field positions and
//                the default header sync pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_sched_pkg;

   // Scheduler FSM states, explicitly encoded in 3 bits
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARB      = 3'd1,
      ST_HDR_SEND = 3'd2,
      ST_HDR_WAIT = 3'd3,
      ST_RD       = 3'd4,
      ST_LATCH    = 3'd5,
      ST_SEND     = 3'd6,
      ST_WAIT     = 3'd7
   } sched_state_t;

   // Header word layout: sync [31:16], reserved [15:9], channel [8], seq [7:0]
   localparam int c_hdr_sync_msb = 31;
   localparam int c_hdr_sync_lsb = 16;
   localparam int c_hdr_rsvd_msb = 15;
   localparam int c_hdr_rsvd_lsb = 9;
   localparam int c_hdr_ch_bit   = 8;
   localparam int c_hdr_seq_msb  = 7;
   localparam int c_hdr_seq_lsb  = 0;

   localparam logic [15:0] c_sync_word_default = 16'hA55A;

   // Assemble a burst header word from its fields
   function automatic logic [31:0] build_header(input logic [15:0] sync,
                                                input logic        ch,
                                                input logic [7:0]  seq);
      logic [31:0] hdr;
      hdr = '0;
      hdr[c_hdr_sync_msb:c_hdr_sync_lsb] = sync;
      hdr[c_hdr_rsvd_msb:c_hdr_rsvd_lsb] = '0;
      hdr[c_hdr_ch_bit]                  = ch;
      hdr[c_hdr_seq_msb:c_hdr_seq_lsb]   = seq;
      return hdr;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_word_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-request round-robin arbiter. The grant is combinational
//                from the requests and the last-grant register; the register
//                only moves when the owner strobes grant_stb.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       grant_stb,
   output logic       gnt_valid,
   output logic       gnt_ch,
   output logic       last_ch
);

   logic r_last_ch;
   logic w_gnt_ch;

   // Pick the requester; on contention favour the one not granted last time
   always_comb begin
      w_gnt_ch = r_last_ch;
      case (req)
         2'b01:   w_gnt_ch = 1'b0;
         2'b10:   w_gnt_ch = 1'b1;
         2'b11:   w_gnt_ch = ~r_last_ch;
         default: w_gnt_ch = r_last_ch;
      endcase
   end

   // Remember the winner; reset to 1 so channel 0 wins the first contest
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_ch <= 1'b1;
      end else if (grant_stb && (req != 2'b00)) begin
         r_last_ch <= w_gnt_ch;
      end
   end

   assign gnt_valid = (req != 2'b00);
   assign gnt_ch    = w_gnt_ch;
   assign last_ch   = r_last_ch;

endmodule
`default_nettype wire

// File: rtl/uart_word_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_sched
//  Description : Shares one 32-bit word UART transmitter between two FIFOs.
//                Round-robin burst scheduling, up to BURST_LEN payload words
//                per burst, optional header word in front of every burst.
//                Optional feature macro: UART_SCHED_HEADER_EN (header word).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_word_sched
   import uart_sched_pkg::*;
#(
   parameter int          BURST_LEN = 16,
   parameter logic [15:0] SYNC_WORD = c_sync_word_default
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sched_en,
   input  logic [1:0]  fifo_empty,
   output logic [1:0]  fifo_rd_en,
   input  logic [31:0] fifo_rd_data0,
   input  logic [31:0] fifo_rd_data1,
   output logic [31:0] tx_data,
   output logic        tx_start,
   input  logic        tx_done,
   output logic        busy,
   output logic        grant_ch,
   output logic [7:0]  frame_seq
);

   localparam logic [7:0] c_burst_len = 8'(BURST_LEN);

   sched_state_t r_state;
   sched_state_t w_next_state;

   logic [7:0]  r_word_cnt;
   logic [7:0]  w_word_cnt_d;
   logic [7:0]  r_frame_seq;
   logic [7:0]  w_frame_seq_d;
   logic [31:0] r_tx_data;
   logic [31:0] w_tx_data_d;
   logic        r_tx_start;
   logic        w_tx_start_d;
   logic [1:0]  r_fifo_rd_en;
   logic [1:0]  w_fifo_rd_en_d;
   logic        r_busy;
   logic        w_busy_d;

   logic        w_gnt_valid;
   logic        w_gnt_ch;
   logic        w_last_ch;
   logic        w_grant_stb;
   logic        w_cur_ch;
   logic        w_rd_ok;
   logic        w_burst_end;
   logic [31:0] w_rd_data;

   assign w_grant_stb = (r_state == ST_ARB) && w_gnt_valid;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (~fifo_empty),
      .grant_stb (w_grant_stb),
      .gnt_valid (w_gnt_valid),
      .gnt_ch    (w_gnt_ch),
      .last_ch   (w_last_ch)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic. RD follows the read strobe issued on entry to RD:
   // a strobe means a word is coming, no strobe ends the burst.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (sched_en && (fifo_empty != 2'b11)) w_next_state = ST_ARB;
         end
         ST_ARB: begin
            if (w_gnt_valid) begin
`ifdef UART_SCHED_HEADER_EN
               w_next_state = ST_HDR_SEND;
`else
               w_next_state = ST_RD;
`endif
            end else begin
               w_next_state = ST_IDLE;
            end
         end
`ifdef UART_SCHED_HEADER_EN
         ST_HDR_SEND: w_next_state = ST_HDR_WAIT;
         ST_HDR_WAIT: begin
            if (tx_done) w_next_state = ST_RD;
         end
`endif
         ST_RD:    w_next_state = (r_fifo_rd_en != 2'b00) ? ST_LATCH : ST_IDLE;
         ST_LATCH: w_next_state = ST_SEND;
         ST_SEND:  w_next_state = ST_WAIT;
         ST_WAIT: begin
            if (tx_done) w_next_state = (r_word_cnt < c_burst_len) ? ST_RD : ST_IDLE;
         end
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Output logic: compute next values of every registered output. Strobes
   // are decoded from the next state so they are high exactly in that state.
   always_comb begin
      w_cur_ch    = (r_state == ST_ARB) ? w_gnt_ch : w_last_ch;
      w_rd_ok     = sched_en && !fifo_empty[w_cur_ch];
      w_rd_data   = w_last_ch ? fifo_rd_data1 : fifo_rd_data0;
      w_burst_end = ((r_state == ST_RD) && (r_fifo_rd_en == 2'b00)) ||
                    ((r_state == ST_WAIT) && tx_done && (r_word_cnt >= c_burst_len));

      w_fifo_rd_en_d = 2'b00;
      if ((w_next_state == ST_RD) && w_rd_ok) w_fifo_rd_en_d[w_cur_ch] = 1'b1;

      w_tx_start_d = (w_next_state == ST_SEND) || (w_next_state == ST_HDR_SEND);
      w_busy_d     = (w_next_state != ST_IDLE);

      w_tx_data_d = r_tx_data;
      if (w_next_state == ST_HDR_SEND) begin
         w_tx_data_d = build_header(SYNC_WORD, w_gnt_ch, r_frame_seq);
      end else if (r_state == ST_LATCH) begin
         w_tx_data_d = w_rd_data;
      end

      w_word_cnt_d = r_word_cnt;
      if (w_grant_stb) begin
         w_word_cnt_d = 8'd0;
      end else if (r_state == ST_SEND) begin
         w_word_cnt_d = r_word_cnt + 8'd1;
      end

      w_frame_seq_d = w_burst_end ? (r_frame_seq + 8'd1) : r_frame_seq;
   end

   // Output and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_data    <= '0;
         r_tx_start   <= 1'b0;
         r_fifo_rd_en <= 2'b00;
         r_busy       <= 1'b0;
         r_word_cnt   <= 8'd0;
         r_frame_seq  <= 8'd0;
      end else begin
         r_tx_data    <= w_tx_data_d;
         r_tx_start   <= w_tx_start_d;
         r_fifo_rd_en <= w_fifo_rd_en_d;
         r_busy       <= w_busy_d;
         r_word_cnt   <= w_word_cnt_d;
         r_frame_seq  <= w_frame_seq_d;
      end
   end

   assign tx_data    = r_tx_data;
   assign tx_start   = r_tx_start;
   assign fifo_rd_en = r_fifo_rd_en;
   assign busy       = r_busy;
   assign grant_ch   = w_last_ch;
   assign frame_seq  = r_frame_seq;

endmodule
`default_nettype wire
